// File: rtl/sd_write_model_pkg.sv
// Shared constants and FSM encoding for the DDR-to-SD sector writer.
package sd_write_model_pkg;

  localparam int unsigned SECTOR_WORDS = 256;
  localparam int unsigned BUF_AW       = 8;
  localparam int unsigned CNT_W        = BUF_AW + 1;

  localparam logic [CNT_W-1:0] SEC_WORDS_CNT = CNT_W'(SECTOR_WORDS);
  localparam logic [CNT_W-1:0] SEC_LAST_CNT  = CNT_W'(SECTOR_WORDS - 1);
  localparam logic [CNT_W-1:0] BUF_DEPTH     = CNT_W'(1 << BUF_AW);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FILL      = 3'd1,
    S_START     = 3'd2,
    S_XFER      = 3'd3,
    S_WAIT_DONE = 3'd4,
    S_DONE      = 3'd5
  } state_t;

endpackage

// File: rtl/sd_write_model_buf.sv
// One-sector word FIFO with registered read; popping an empty FIFO yields zero.
module sd_wr_buf
  import sd_write_model_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [15:0]      push_data_i,
  input  logic             pop_i,
  output logic [15:0]      rd_data_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  logic [15:0]       mem_q [0:(1<<BUF_AW)-1];
  logic [BUF_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic [15:0]       rd_data_q;
  logic              do_push, do_pop;

  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && ((count_q != BUF_DEPTH) || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rd_data_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + BUF_AW'(1);
      if (do_pop) begin
        rd_ptr_q  <= rd_ptr_q + BUF_AW'(1);
        rd_data_q <= mem_q[rd_ptr_q];
      end else if (pop_i) begin
        rd_data_q <= '0;
      end
      if (do_push && !do_pop)      count_q <= count_q + CNT_W'(1);
      else if (!do_push && do_pop) count_q <= count_q - CNT_W'(1);
    end
  end

  assign rd_data_o = rd_data_q;
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;

endmodule

// File: rtl/sd_write_model.sv
// Streams consecutive DDR words into consecutive SD sectors, one buffered sector at a time.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// S_IDLE      | waiting for start
// S_FILL      | requesting and collecting one sector of words from DDR
// S_START     | wr_start_en pulse for the current sector
// S_XFER      | handing buffered words to the SD controller on request
// S_WAIT_DONE | waiting for wr_busy to fall, then next sector or finish
// S_DONE      | done pulse
module sd_write_model
  import sd_write_model_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic [31:0] sd_sec_num_i,
  input  logic [31:0] sec_addr_start_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_underflow_o,
  output logic        ddr_rd_req_o,
  input  logic        ddr_rd_ack_i,
  input  logic        ddr_rd_valid_i,
  input  logic [15:0] ddr_rd_data_i,
  output logic        wr_start_en_o,
  output logic [31:0] wr_sec_addr_o,
  input  logic        wr_busy_i,
  input  logic        sd_wr_req_i,
  output logic [15:0] sd_wr_data_o
);

  state_t           state_q;
  logic [31:0]      sec_num_q, sec_cnt_q, wr_sec_addr_q;
  logic [CNT_W-1:0] req_cnt_q, rcv_cnt_q, pop_cnt_q;
  logic             busy_q, done_q, err_q, wr_start_en_q;
  logic             wr_busy_s0_q, wr_busy_s1_q;

  logic             buf_push, buf_pop, buf_empty, wr_busy_fall;
  logic [CNT_W-1:0] buf_count;
  logic [15:0]      buf_rd_data;

  assign ddr_rd_req_o = (state_q == S_FILL) && (req_cnt_q < SEC_WORDS_CNT);
  assign buf_push     = (state_q == S_FILL) && ddr_rd_valid_i && (rcv_cnt_q < SEC_WORDS_CNT);
  assign buf_pop      = (state_q == S_XFER) && sd_wr_req_i;
  assign wr_busy_fall = wr_busy_s1_q & ~wr_busy_s0_q;

  sd_wr_buf u_buf (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (buf_push),
    .push_data_i (ddr_rd_data_i),
    .pop_i       (buf_pop),
    .rd_data_o   (buf_rd_data),
    .empty_o     (buf_empty),
    .count_o     (buf_count)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      sec_num_q     <= '0;
      sec_cnt_q     <= '0;
      wr_sec_addr_q <= '0;
      req_cnt_q     <= '0;
      rcv_cnt_q     <= '0;
      pop_cnt_q     <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      wr_start_en_q <= 1'b0;
      wr_busy_s0_q  <= 1'b0;
      wr_busy_s1_q  <= 1'b0;
    end else begin
      wr_busy_s0_q  <= wr_busy_i;
      wr_busy_s1_q  <= wr_busy_s0_q;
      done_q        <= 1'b0;
      wr_start_en_q <= 1'b0;
      if (sd_wr_req_i && buf_empty) err_q <= 1'b1;
      if (ddr_rd_req_o && ddr_rd_ack_i) req_cnt_q <= req_cnt_q + CNT_W'(1);
      if (buf_push) rcv_cnt_q <= rcv_cnt_q + CNT_W'(1);
      if (buf_pop)  pop_cnt_q <= pop_cnt_q + CNT_W'(1);

      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            err_q         <= 1'b0;
            sec_num_q     <= sd_sec_num_i;
            sec_cnt_q     <= '0;
            wr_sec_addr_q <= sec_addr_start_i;
            req_cnt_q     <= '0;
            rcv_cnt_q     <= '0;
            pop_cnt_q     <= '0;
            if (sd_sec_num_i == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_FILL;
              busy_q  <= 1'b1;
            end
          end
        end
        S_FILL: begin
          // Start the sector write only once a full sector is actually buffered.
          if ((rcv_cnt_q == SEC_WORDS_CNT) && (buf_count == BUF_DEPTH)) begin
            state_q       <= S_START;
            wr_start_en_q <= 1'b1;
          end
        end
        S_START: state_q <= S_XFER;
        S_XFER: begin
          if (buf_pop && (pop_cnt_q == SEC_LAST_CNT)) state_q <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (wr_busy_fall) begin
            sec_cnt_q     <= sec_cnt_q + 32'd1;
            wr_sec_addr_q <= wr_sec_addr_q + 32'd1;
            req_cnt_q     <= '0;
            rcv_cnt_q     <= '0;
            pop_cnt_q     <= '0;
            if (sec_cnt_q == sec_num_q - 32'd1) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              state_q <= S_FILL;
            end
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign err_underflow_o = err_q;
  assign wr_start_en_o   = wr_start_en_q;
  assign wr_sec_addr_o   = wr_sec_addr_q;
  assign sd_wr_data_o    = buf_rd_data;

endmodule

// File: tb/tb_sd_write_model.sv
// Directed bench: DDR responder with 3-cycle latency and an SD controller model feed the DUT.
module tb_sd_write_model;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] sd_sec_num, sec_addr_start;
  logic        busy, done, err_underflow;
  logic        ddr_rd_req;
  logic        ddr_rd_ack   = 1'b0;
  logic        ddr_rd_valid = 1'b0;
  logic [15:0] ddr_rd_data  = 16'h0;
  logic        wr_start_en;
  logic [31:0] wr_sec_addr;
  logic        wr_busy   = 1'b0;
  logic        model_req = 1'b0;
  logic        force_req;
  logic        sd_wr_req;
  logic [15:0] sd_wr_data;

  assign sd_wr_req = force_req | model_req;

  always #5 clk = ~clk;

  sd_write_model dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start_i          (start),
    .sd_sec_num_i     (sd_sec_num),
    .sec_addr_start_i (sec_addr_start),
    .busy_o           (busy),
    .done_o           (done),
    .err_underflow_o  (err_underflow),
    .ddr_rd_req_o     (ddr_rd_req),
    .ddr_rd_ack_i     (ddr_rd_ack),
    .ddr_rd_valid_i   (ddr_rd_valid),
    .ddr_rd_data_i    (ddr_rd_data),
    .wr_start_en_o    (wr_start_en),
    .wr_sec_addr_o    (wr_sec_addr),
    .wr_busy_i        (wr_busy),
    .sd_wr_req_i      (sd_wr_req),
    .sd_wr_data_o     (sd_wr_data)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Model state (written only by the model block below)
  logic        pv [3];
  logic [15:0] pd [3];
  logic [15:0] ddr_word = 16'h0;
  int ddr_acc = 0, req_cycles = 0, last_valid_cyc = 0;
  int sd_state = 0, words = 0, gap = 0;
  logic cap_pending = 1'b0;
  logic [15:0] cap_q [$];
  logic [31:0] addr_q [$];
  int start_cnt = 0, start_cyc = 0, done_cnt = 0, done_cyc = 0, fall_cyc = 0;
  logic done_busy = 1'b0;

  // Knobs written only by the main sequence
  logic ack_rand = 1'b0;
  logic sd_pace  = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin pv[i] = 1'b0; pd[i] = 16'h0; end
      ddr_rd_valid = 1'b0;
      ddr_rd_ack   = 1'b0;
      ddr_rd_data  = 16'h0;
      model_req    = 1'b0;
      wr_busy      = 1'b0;
      sd_state     = 0;
      cap_pending  = 1'b0;
    end else begin
      ddr_rd_valid = pv[2];
      ddr_rd_data  = pd[2];
      if (pv[2]) last_valid_cyc = cyc;
      pv[2] = pv[1]; pd[2] = pd[1];
      pv[1] = pv[0]; pd[1] = pd[0];
      ddr_rd_ack = ack_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      pv[0] = ddr_rd_req && ddr_rd_ack;
      pd[0] = ddr_word;
      if (pv[0]) begin ddr_word = ddr_word + 16'd1; ddr_acc++; end
      if (ddr_rd_req) req_cycles++;

      if (cap_pending) cap_q.push_back(sd_wr_data);
      cap_pending = 1'b0;
      case (sd_state)
        0: begin
          model_req = 1'b0;
          if (wr_start_en) begin
            addr_q.push_back(wr_sec_addr);
            start_cnt++;
            start_cyc = cyc;
            wr_busy  = 1'b1;
            words    = 0;
            sd_state = 1;
          end
        end
        1: begin
          if (words < 256) begin
            model_req = sd_pace ? ~model_req : 1'b1;
            if (model_req) begin words++; cap_pending = 1'b1; end
          end else begin
            model_req = 1'b0;
            gap = 2;
            sd_state = 2;
          end
        end
        2: begin
          if (gap == 0) begin
            wr_busy  = 1'b0;
            fall_cyc = cyc;
            sd_state = 0;
          end else gap--;
        end
        default: sd_state = 0;
      endcase

      if (done) begin done_cnt++; done_cyc = cyc; done_busy = busy; end
    end
  end

  // Snapshots taken before each transfer
  int n_done, n_start, n_cap, n_addr, n_acc, n_reqc, mis, wait_i;
  logic [15:0] base;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic [31:0] num, input logic [31:0] addr);
    @(posedge clk);
    n_done = done_cnt; n_start = start_cnt; n_cap = cap_q.size(); n_addr = addr_q.size();
    n_acc = ddr_acc; n_reqc = req_cycles; base = ddr_word;
    @(negedge clk);
    sd_sec_num = num; sec_addr_start = addr; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    wait_i = 0;
    while (done_cnt == n_done && wait_i < 20000) begin @(posedge clk); wait_i++; end
    chk(tag, 32'(done_cnt != n_done), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_words(input string tag, input int nwords);
    chk(tag, cap_q.size() - n_cap, nwords);
    mis = 0;
    for (int k = 0; k < nwords && (n_cap + k) < cap_q.size(); k++)
      if (cap_q[n_cap + k] !== 16'(base + 16'(k))) mis++;
    chk({tag, "_order"}, mis, 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; sd_sec_num = '0; sec_addr_start = '0; force_req = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err_underflow), 0);
    chk("rst_ddr_req", 32'(ddr_rd_req), 0);
    chk("rst_wr_start", 32'(wr_start_en), 0);
    chk("rst_addr", wr_sec_addr, 0);
    chk("rst_data", 32'(sd_wr_data), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Underflow: request while the buffer is empty
    force_req = 1'b1;
    @(negedge clk);
    force_req = 1'b0;
    chk("uf_flag", 32'(err_underflow), 1);
    chk("uf_data", 32'(sd_wr_data), 0);
    @(negedge clk);
    chk("uf_sticky", 32'(err_underflow), 1);

    // Single sector, also clears the underflow flag
    launch(32'd1, 32'h1000);
    chk("single_busy_rise", 32'(busy), 1);
    chk("uf_cleared", 32'(err_underflow), 0);
    wait_done("single_done");
    chk("single_starts", start_cnt - n_start, 1);
    chk("single_addr", addr_q[n_addr], 32'h1000);
    check_words("single_words", 256);
    chk("single_acc", ddr_acc - n_acc, 256);
    chk("single_start_lat", start_cyc - last_valid_cyc, 2);
    chk("single_done_lat", done_cyc - fall_cyc, 2);
    chk("single_done_busy", 32'(done_busy), 0);
    chk("single_err", 32'(err_underflow), 0);
    chk("single_busy_end", 32'(busy), 0);
    chk("single_done_cnt", done_cnt - n_done, 1);

    // Multi-sector with paced SD requests
    sd_pace = 1'b1;
    launch(32'd3, 32'h1000);
    wait_done("multi_done");
    chk("multi_starts", start_cnt - n_start, 3);
    chk("multi_addr0", addr_q[n_addr], 32'h1000);
    chk("multi_addr1", addr_q[n_addr + 1], 32'h1001);
    chk("multi_addr2", addr_q[n_addr + 2], 32'h1002);
    check_words("multi_words", 768);
    chk("multi_done_cnt", done_cnt - n_done, 1);
    chk("multi_err", 32'(err_underflow), 0);
    sd_pace = 1'b0;

    // Zero sectors
    launch(32'd0, 32'h55);
    wait_done("zero_done");
    chk("zero_req", req_cycles - n_reqc, 0);
    chk("zero_starts", start_cnt - n_start, 0);
    chk("zero_done_cnt", done_cnt - n_done, 1);

    // DDR back-pressure
    ack_rand = 1'b1;
    launch(32'd2, 32'h2000);
    wait_done("bp_done");
    chk("bp_acc", ddr_acc - n_acc, 512);
    chk("bp_starts", start_cnt - n_start, 2);
    chk("bp_addr1", addr_q[n_addr + 1], 32'h2001);
    check_words("bp_words", 512);
    ack_rand = 1'b0;

    // Reset in the middle of a sector transfer
    launch(32'd2, 32'h3000);
    wait_i = 0;
    while (cap_q.size() < n_cap + 20 && wait_i < 5000) begin @(posedge clk); wait_i++; end
    chk("mid_reached", 32'(cap_q.size() >= n_cap + 20), 1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_busy", 32'(busy), 0);
    chk("mid_done", 32'(done), 0);
    chk("mid_err", 32'(err_underflow), 0);
    chk("mid_ddr_req", 32'(ddr_rd_req), 0);
    chk("mid_wr_start", 32'(wr_start_en), 0);
    chk("mid_addr", wr_sec_addr, 0);
    chk("mid_data", 32'(sd_wr_data), 0);
    chk("mid_no_done", done_cnt - n_done, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Address wrap after the reset
    launch(32'd2, 32'hFFFF_FFFF);
    wait_done("wrap_done");
    chk("wrap_starts", start_cnt - n_start, 2);
    chk("wrap_addr0", addr_q[n_addr], 32'hFFFF_FFFF);
    chk("wrap_addr1", addr_q[n_addr + 1], 32'h0000_0000);
    check_words("wrap_words", 512);
    chk("wrap_done_cnt", done_cnt - n_done, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
